// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: opcodes, funct
// codes, ALU operation codes, FSM states, error codes and the control bundle.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RFMT = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_FUNCT   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_ADDI_EX = 4'd8,
    S_ADDI_WB = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  // Every datapath select/enable driven by the sequencer, in one bundle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_alu_funct_decode.sv
// R-format funct field to ALU operation decoder (purely combinational).
module alu_funct_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_op,
  output logic       o_illegal
);

  // Map funct to ALU op; unsupported codes raise the illegal flag
  always_comb begin
    o_alu_op  = ALU_ADD;
    o_illegal = 1'b0;
    case (i_funct)
      FN_ADD:  o_alu_op = ALU_ADD;
      FN_SUB:  o_alu_op = ALU_SUB;
      FN_AND:  o_alu_op = ALU_AND;
      FN_OR:   o_alu_op = ALU_OR;
      FN_NOR:  o_alu_op = ALU_NOR;
      FN_SLT:  o_alu_op = ALU_SLT;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control sequencer. Walks each instruction through
// fetch/decode/execute/memory/write-back states and drives the datapath
// selects and enables. Memory uses a ready handshake with an optional
// timeout; illegal encodings and timeouts park the FSM in HALT until reset.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic [1:0] err_code,
  output logic       retire
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_err;
  logic [1:0]       w_err_nxt;
  logic [CNT_W-1:0] r_wait;
  logic             r_quiet;
  ctrl_t            w_ctrl;
  ctrl_t            w_out;
  logic [3:0]       w_funct_op;
  logic             w_funct_bad;
  logic             w_mem_state;
  logic             w_waiting;
  logic             w_wait_last;
  logic             w_unused_zero;

  // The branch decision (zero ^ branch_ne) is resolved in the datapath.
  assign w_unused_zero = zero;

  alu_funct_decode u_funct_decode (
    .i_funct   (funct),
    .o_alu_op  (w_funct_op),
    .o_illegal (w_funct_bad)
  );

  // A wait cycle is one spent in a memory state without ready. The timeout
  // fires only when the count would reach the limit and ready is still low,
  // so a ready arriving on the limit cycle still completes the access.
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);
  assign w_waiting   = w_mem_state && !mem_ready && !r_quiet;
  assign w_wait_last = (MEM_TIMEOUT != 0) && w_waiting &&
                       (32'(r_wait) + 32'd1 == MEM_TIMEOUT);

  // Moore decode of controls per state plus next-state dispatch
  always_comb begin
    w_ctrl      = '0;
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = 2'd1;
        w_ctrl.alu_op    = ALU_ADD;
        if (mem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_state_nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is dispatched
        w_ctrl.alu_src_b = 2'd3;
        w_ctrl.alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW:   w_state_nxt = S_MEMADR;
          OP_RFMT:        w_state_nxt = S_EXEC;
          OP_BEQ, OP_BNE: w_state_nxt = S_BRANCH;
          OP_ADDI:        w_state_nxt = S_ADDI_EX;
          OP_J:           w_state_nxt = S_JUMP;
          default: begin
            w_state_nxt = S_HALT;
            w_err_nxt   = ERR_OPCODE;
          end
        endcase
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 2'd2;
        w_ctrl.alu_op    = ALU_ADD;
        w_state_nxt      = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
        if (mem_ready) w_state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.retire     = 1'b1;
        w_state_nxt       = S_FETCH;
      end
      S_MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
        if (mem_ready) begin
          w_ctrl.retire = 1'b1;
          w_state_nxt   = S_FETCH;
        end
      end
      S_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = w_funct_op;
        if (w_funct_bad) begin
          w_state_nxt = S_HALT;
          w_err_nxt   = ERR_FUNCT;
        end else begin
          w_state_nxt = S_ALUWB;
        end
      end
      S_ALUWB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.retire    = 1'b1;
        w_state_nxt      = S_FETCH;
      end
      S_ADDI_EX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 2'd2;
        w_ctrl.alu_op    = ALU_ADD;
        w_state_nxt      = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.retire    = 1'b1;
        w_state_nxt      = S_FETCH;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_op        = ALU_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.branch_ne     = (opcode == OP_BNE);
        w_ctrl.pc_source     = 2'd1;
        w_ctrl.retire        = 1'b1;
        w_state_nxt          = S_FETCH;
      end
      S_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = 2'd2;
        w_ctrl.retire    = 1'b1;
        w_state_nxt      = S_FETCH;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
    if (w_wait_last) begin
      w_state_nxt = S_HALT;
      w_err_nxt   = ERR_TIMEOUT;
    end
    // The cycle after reset is silent: FETCH is held and no request issues
    if (r_quiet) w_state_nxt = S_FETCH;
  end

  assign w_out         = r_quiet ? '0 : w_ctrl;
  assign pc_write      = w_out.pc_write;
  assign pc_write_cond = w_out.pc_write_cond;
  assign branch_ne     = w_out.branch_ne;
  assign iord          = w_out.iord;
  assign mem_read      = w_out.mem_read;
  assign mem_write     = w_out.mem_write;
  assign ir_write      = w_out.ir_write;
  assign mem_to_reg    = w_out.mem_to_reg;
  assign reg_dst       = w_out.reg_dst;
  assign reg_write     = w_out.reg_write;
  assign alu_src_a     = w_out.alu_src_a;
  assign alu_src_b     = w_out.alu_src_b;
  assign alu_op        = w_out.alu_op;
  assign pc_source     = w_out.pc_source;
  assign retire        = w_out.retire;
  assign halted        = (r_state == S_HALT) && !r_quiet;
  assign err_code      = r_err;

  // State, sticky error code, memory wait counter and post-reset silence flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_err   <= ERR_NONE;
      r_wait  <= '0;
      r_quiet <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      r_wait  <= w_waiting ? r_wait + 1'b1 : '0;
      r_quiet <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random
// instruction streams, compared against an instruction-level cost model.
module tb_multicycle_ctrl;

  localparam int TMO = 4;

  logic       clock, reset, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source, err_code;
  logic [3:0] alu_op;
  logic       halted, retire;
  logic [23:0] all_outs;

  int n_pass  = 0;
  int n_total = 0;

  // Per-instruction observations
  int cyc, n_ret, n_pcw, n_pcwc, n_regw, n_memw, n_memr, n_irw, n_both, n_memw_iord;
  logic       end_halt;
  logic [1:0] end_err;
  logic [3:0] s_aluop  [32];
  logic       s_regdst [32];
  logic       s_regw   [32];
  logic       s_m2r    [32];
  logic       s_bne    [32];
  logic       s_pcwc   [32];
  logic [1:0] s_pcsrc  [32];

  logic [5:0] rnd_ops [7] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h05, 6'h02};
  logic [5:0] rnd_fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .halted(halted), .err_code(err_code),
    .retire(retire)
  );

  assign all_outs = {pc_write, pc_write_cond, branch_ne, iord, mem_read,
                     mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                     alu_src_a, alu_src_b, alu_op, pc_source, halted,
                     err_code, retire};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference ALU mapping from the R-format funct table
  function automatic logic [3:0] ref_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 4'd2;
      6'h22: return 4'd6;
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h27: return 4'd12;
      6'h2A: return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  function automatic bit ref_fn_ok(input logic [5:0] fn);
    return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
           (fn == 6'h25) || (fn == 6'h27) || (fn == 6'h2A);
  endfunction

  // Runs one instruction from an aligned FETCH. wf = fetch wait cycles,
  // wm = wait cycles of the data access (which starts at cycle wf+4).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int wf, input int wm);
    bit done;
    int mstart;
    mstart = wf + 4;
    done = 0; cyc = -1; end_halt = 1'b0; end_err = 2'd0;
    n_ret = 0; n_pcw = 0; n_pcwc = 0; n_regw = 0; n_memw = 0; n_memr = 0;
    n_irw = 0; n_both = 0; n_memw_iord = 0;
    for (int c = 1; c < 32 && !done; c++) begin
      opcode = op; funct = fn; zero = z;
      mem_ready = !((c <= wf) || (c >= mstart && c < mstart + wm));
      @(negedge clock);
      n_ret  += int'(retire);
      n_pcw  += int'(pc_write);
      n_pcwc += int'(pc_write_cond);
      n_regw += int'(reg_write);
      n_memw += int'(mem_write);
      n_memr += int'(mem_read);
      n_irw  += int'(ir_write);
      n_both += int'(mem_read & mem_write);
      n_memw_iord += int'(mem_write & iord);
      s_aluop[c] = alu_op; s_regdst[c] = reg_dst; s_regw[c] = reg_write;
      s_m2r[c] = mem_to_reg; s_bne[c] = branch_ne; s_pcwc[c] = pc_write_cond;
      s_pcsrc[c] = pc_source;
      if (retire || halted) begin
        done = 1; cyc = c; end_halt = halted; end_err = err_code;
      end
      @(posedge clock); #1;
    end
  endtask

  // Instruction-level model: cycle cost and per-signal activity totals
  task automatic check_instr(input string tag, input logic [5:0] op,
                             input logic [5:0] fn, input logic z,
                             input int wf, input int wm);
    int e_cyc, e_pcw, e_pcwc, e_regw, e_memw, e_memr, e_irw, e_err, e_ret;
    bit e_halt;
    run_instr(op, fn, z, wf, wm);
    e_halt = 0; e_err = 0; e_irw = 1; e_pcw = 1; e_pcwc = 0;
    e_regw = 0; e_memw = 0; e_memr = 1 + wf; e_cyc = 0;
    if (wf >= TMO) begin
      e_halt = 1; e_err = 3; e_cyc = TMO + 1; e_irw = 0; e_pcw = 0; e_memr = TMO;
    end else begin
      case (op)
        6'h23: begin e_cyc = 5 + wf + wm; e_regw = 1; e_memr = 2 + wf + wm; end
        6'h2B: begin e_cyc = 4 + wf + wm; e_memw = 1 + wm; end
        6'h00: if (ref_fn_ok(fn)) begin e_cyc = 4 + wf; e_regw = 1; end
               else begin e_halt = 1; e_err = 2; e_cyc = 4 + wf; end
        6'h08: begin e_cyc = 4 + wf; e_regw = 1; end
        6'h04, 6'h05: begin e_cyc = 3 + wf; e_pcwc = 1; end
        6'h02: begin e_cyc = 3 + wf; e_pcw = 2; end
        default: begin e_halt = 1; e_err = 1; e_cyc = 3 + wf; end
      endcase
    end
    e_ret = e_halt ? 0 : 1;
    chk({tag, ".cycles"}, cyc, e_cyc);
    chk({tag, ".retire"}, n_ret, e_ret);
    chk({tag, ".halted"}, end_halt, e_halt);
    chk({tag, ".err"}, end_err, e_err);
    chk({tag, ".pc_write"}, n_pcw, e_pcw);
    chk({tag, ".pc_wcond"}, n_pcwc, e_pcwc);
    chk({tag, ".reg_write"}, n_regw, e_regw);
    chk({tag, ".mem_write"}, n_memw, e_memw);
    chk({tag, ".mem_read"}, n_memr, e_memr);
    chk({tag, ".ir_write"}, n_irw, e_irw);
    chk({tag, ".rd_wr_excl"}, n_both, 0);
    chk({tag, ".wr_iord"}, n_memw_iord, e_memw);
    if (op == 6'h00 && ref_fn_ok(fn) && wf < TMO)
      chk({tag, ".alu_op"}, s_aluop[wf + 3], ref_alu(fn));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    int cls, wf, wm;
    logic [5:0] op, fn;
    logic z;
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;

    // Reset state, while reset is held and on the first cycle after release
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst.hold_outs", all_outs, 24'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clock);
    chk("rst.quiet_outs", all_outs, 24'd0);
    @(posedge clock); #1;

    // LW zero-wait: write-back in cycle 5 from MDR
    check_instr("lw", 6'h23, 6'h00, 1'b0, 0, 0);
    chk("lw.c5_reg_write", s_regw[5], 1'b1);
    chk("lw.c5_mem_to_reg", s_m2r[5], 1'b1);

    // SW with three data-side wait cycles: retire in cycle 7
    check_instr("sw_w3", 6'h2B, 6'h00, 1'b0, 0, 3);

    // Branches
    check_instr("beq", 6'h04, 6'h00, 1'b1, 0, 0);
    chk("beq.c3_pcwc", s_pcwc[3], 1'b1);
    chk("beq.c3_bne", s_bne[3], 1'b0);
    chk("beq.c3_pcsrc", s_pcsrc[3], 2'd1);
    check_instr("bne", 6'h05, 6'h00, 1'b0, 0, 0);
    chk("bne.c3_bne", s_bne[3], 1'b1);

    // R-type SUB
    check_instr("rsub", 6'h00, 6'h22, 1'b0, 0, 0);
    chk("rsub.c4_reg_dst", s_regdst[4], 1'b1);

    // Fetch ready arriving on the cycle the wait count reaches the limit
    check_instr("addi_fw3", 6'h08, 6'h00, 1'b0, 3, 0);
    check_instr("lw_mw3", 6'h23, 6'h00, 1'b0, 1, 3);
    check_instr("j", 6'h02, 6'h00, 1'b0, 0, 0);

    // Random legal instruction stream with random waits below the limit
    for (int k = 0; k < 24; k++) begin
      cls = $urandom_range(0, 6);
      op  = rnd_ops[cls];
      fn  = rnd_fns[$urandom_range(0, 5)];
      z   = 1'($urandom_range(0, 1));
      wf  = $urandom_range(0, TMO - 1);
      wm  = $urandom_range(0, TMO - 1);
      check_instr($sformatf("rnd%0d", k), op, fn, z, wf, wm);
    end

    // Reset in the middle of a data read
    opcode = 6'h23; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
    end
    mem_ready = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk("rstrd.memrd_req", {mem_read, iord}, 2'b11);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rstrd.quiet_outs", all_outs, 24'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("rstrd.resume_fetch", {mem_read, iord, halted, err_code}, 5'b10000);
    @(posedge clock); #1;
    check_instr("rstrd.next", 6'h02, 6'h00, 1'b0, 0, 0);

    // Illegal opcode halts and stays halted
    check_instr("bad_op", 6'h3F, 6'h00, 1'b0, 0, 0);
    mem_ready = 1'b1;
    @(negedge clock);
    chk("bad_op.sticky", {halted, retire, mem_read, err_code}, 5'b10001);
    @(posedge clock); #1;
    do_reset();

    // Illegal funct
    check_instr("bad_fn", 6'h00, 6'h3F, 1'b0, 1, 0);
    do_reset();

    // Fetch never completes: timeout after TMO wait cycles
    check_instr("tmo", 6'h23, 6'h00, 1'b0, 10, 0);
    do_reset();

    check_instr("post_tmo", 6'h2B, 6'h00, 1'b0, 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
